// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared frame widths and FSM state encoding
package instr_loader_pkg;
  localparam int FRAME_BITS = 16;
  localparam int OPCODE_W = 4;
  localparam int INSTR_W = 12;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;
endpackage

// File: rtl/instr_loader_sync_edge.sv
// instr_loader_sync_edge: multi-flop synchronizer with a rising-edge pulse on the synchronized output
module instr_loader_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic [STAGES-1:0] sr;
  logic              q;
  // Shift the raw pin through the chain and remember the last synchronized value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      q  <= 1'b0;
    end else begin
      sr <= {sr[STAGES-2:0], din};
      q  <= sr[STAGES-1];
    end
  assign rise = sr[STAGES-1] & ~q;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: synchronizes a serial instruction link and commits 16-bit frames as opcode/instr
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ser_clk,
  input  logic                ser_data,
  input  logic                ser_frame,
  input  logic                btn_in,
  output logic [OPCODE_W-1:0] opcode,
  output logic [INSTR_W-1:0]  instr,
  output logic                inst_done,
  output logic                btn_edge,
  output logic                frame_err
);
  if (FRAME_BITS != instr_loader_pkg::FRAME_BITS) begin : g_bad_frame
    $error("instr_loader: FRAME_BITS must be 16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("instr_loader: SYNC_STAGES must be 2 or 3");
  end
  localparam logic [4:0] FULL = 5'(FRAME_BITS);
  state_t                  state, state_n;
  logic [SYNC_STAGES-1:0]  frame_sr, data_sr;
  logic                    frame_s, data_s, frame_q, pend;
  logic                    clk_rise, btn_rise, bit_ev, err_n;
  logic [FRAME_BITS-1:0]   shreg, shreg_n;
  logic [4:0]              cnt, cnt_n;
  logic                    ovr, ovr_n;
  instr_loader_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (.clk(clk), .rst_n(rst_n), .din(ser_clk), .rise(clk_rise));
  instr_loader_sync_edge #(.STAGES(SYNC_STAGES)) u_btn_sync (.clk(clk), .rst_n(rst_n), .din(btn_in), .rise(btn_rise));
  assign frame_s = frame_sr[SYNC_STAGES-1];
  assign data_s  = data_sr[SYNC_STAGES-1];
  assign bit_ev  = clk_rise & frame_s;
  // Data and frame take the same depth as ser_clk so a bit event sees its own data bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_sr <= '0;
      data_sr  <= '0;
      frame_q  <= 1'b0;
    end else begin
      frame_sr <= {frame_sr[SYNC_STAGES-2:0], ser_frame};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], ser_data};
      frame_q  <= frame_s;
    end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Next state and next frame datapath; a bit coinciding with frame start becomes bit 0
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    ovr_n   = ovr;
    err_n   = 1'b0;
    case (state)
      IDLE:
        if (frame_s && (!frame_q || pend)) begin
          state_n = SHIFT;
          shreg_n = {{(FRAME_BITS-1){1'b0}}, data_s & bit_ev};
          cnt_n   = {4'd0, bit_ev};
          ovr_n   = 1'b0;
        end
      SHIFT:
        if (!frame_s) begin
          state_n = (cnt == FULL && !ovr) ? COMMIT : IDLE;
          err_n   = !(cnt == FULL && !ovr);
        end else if (bit_ev) begin
          ovr_n   = ovr | (cnt == FULL);
          shreg_n = (cnt == FULL) ? shreg : {shreg[FRAME_BITS-2:0], data_s};
          cnt_n   = (cnt == FULL) ? cnt : cnt + 5'd1;
        end
      default: state_n = IDLE;
    endcase
  end
  // Frame datapath, committed outputs and one-cycle pulses; a frame rising during COMMIT is held in pend
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shreg     <= '0;
      cnt       <= '0;
      ovr       <= 1'b0;
      pend      <= 1'b0;
      opcode    <= '0;
      instr     <= '0;
      inst_done <= 1'b0;
      btn_edge  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      ovr       <= ovr_n;
      pend      <= (state == COMMIT) && frame_s && !frame_q;
      inst_done <= state == COMMIT;
      btn_edge  <= btn_rise;
      frame_err <= err_n;
      if (state == COMMIT) {opcode, instr} <= shreg;
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized serial-frame bench against a frame-level reference model
module tb_instr_loader;
  localparam int S = 2;
  logic clk = 0, rst_n = 0, ser_clk = 0, ser_data = 0, ser_frame = 0, btn_in = 0;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        inst_done, btn_edge, frame_err;
  int checks = 0, failures = 0;
  int n_done = 0, n_err = 0, n_btn = 0;
  int exp_done = 0, exp_err = 0, exp_btn = 0;
  logic [3:0]  exp_op = 0;
  logic [11:0] exp_in = 0;
  instr_loader #(.SYNC_STAGES(S), .FRAME_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .ser_clk(ser_clk), .ser_data(ser_data), .ser_frame(ser_frame),
    .btn_in(btn_in), .opcode(opcode), .instr(instr), .inst_done(inst_done),
    .btn_edge(btn_edge), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  // Count high cycles of every pulse output so stretched pulses show up as extra counts
  always @(negedge clk) begin
    if (inst_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
    if (btn_edge === 1'b1) n_btn++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Send nb bits of d MSB first (bits past 16 are random); model: only exactly 16 bits commit d
  task automatic send(input logic [15:0] d, input int nb, input int hp, input bit same, input bit btn, input bit settle);
    int lat;
    lat = 0;
    ser_frame = 1;
    for (int i = 0; i < nb; i++) begin
      ser_data = (i < 16) ? d[15-i] : 1'($urandom);
      if (!(same && i == 0)) cyc(hp);
      ser_clk = 1;
      btn_in = btn && i >= 4 && i < 8;
      cyc(hp);
      ser_clk = 0;
    end
    btn_in = 0;
    cyc(2);
    ser_frame = 0;
    if (nb == 16) begin
      exp_done++;
      {exp_op, exp_in} = d;
    end else exp_err++;
    if (btn) exp_btn++;
    if (settle) begin
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (inst_done === 1'b1 && lat == 0) lat = k;
      end
      if (nb == 16) chk("latency", lat, S + 2);
      chk("done_cnt", n_done, exp_done);
      chk("err_cnt", n_err, exp_err);
      chk("opcode", opcode, exp_op);
      chk("instr", instr, exp_in);
    end
  endtask
  initial begin
    cyc(3);
    chk("rst_opcode", opcode, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pulses", {inst_done, btn_edge, frame_err}, 0);
    rst_n = 1;
    cyc(4);
    send(16'h8A53, 16, 3, 0, 0, 1);
    send(16'h1234, 15, 3, 0, 0, 1);
    send(16'hBEEF, 17, 3, 0, 0, 1);
    ser_frame = 1;
    for (int i = 0; i < 8; i++) begin
      ser_data = 1'($urandom);
      cyc(3);
      ser_clk = 1;
      cyc(3);
      ser_clk = 0;
    end
    rst_n = 0;
    ser_frame = 0;
    cyc(3);
    chk("midrst_opcode", opcode, 0);
    chk("midrst_instr", instr, 0);
    exp_op = 0;
    exp_in = 0;
    rst_n = 1;
    cyc(6);
    chk("midrst_done", n_done, exp_done);
    chk("midrst_err", n_err, exp_err);
    send(16'h0FFF, 16, 3, 0, 0, 1);
    send(16'h5A5A, 16, 3, 0, 1, 1);
    chk("btn_cnt_dir", n_btn, exp_btn);
    send(16'h1001, 16, 3, 0, 0, 0);
    cyc(1);
    send(16'hF00E, 16, 3, 0, 0, 1);
    send(16'hC3A5, 16, 3, 1, 0, 1);
    for (int r = 0; r < 30; r++) begin
      int nb;
      nb = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 17) : 16;
      send(16'($urandom), nb, $urandom_range(2, 5), 1'($urandom), 1'($urandom), 1);
      cyc($urandom_range(1, 4));
    end
    cyc(10);
    chk("btn_cnt", n_btn, exp_btn);
    chk("done_final", n_done, exp_done);
    chk("err_final", n_err, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for every asynchronous pin (legal 2..3).
REQ-002 Parameter FRAME_BITS, default 16: instruction frame length; fixed at 16, any other value is a compile-time error.
REQ-003 clk  input  1  sole system clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ser_clk  input  1  asynchronous serial bit clock; data is sampled on its rising edge.
REQ-006 ser_data  input  1  asynchronous serial instruction data, MSB first.
REQ-007 ser_frame  input  1  asynchronous frame enable, high for the whole transfer.
REQ-008 btn_in  input  1  raw, asynchronous step button.
REQ-009 opcode  output  4  committed instruction bits [15:12].
REQ-010 instr  output  12  committed instruction bits [11:0].
REQ-011 inst_done  output  1  one-cycle pulse marking a new committed instruction.
REQ-012 btn_edge  output  1  one-cycle pulse on each synchronized btn_in rising edge.
REQ-013 frame_err  output  1  one-cycle pulse on an aborted or overrun frame.

Function
REQ-014 ser_clk, ser_data, ser_frame and btn_in shall each pass through SYNC_STAGES flops before use; ser_data and ser_frame shall be sampled from the same pipeline stage as ser_clk.
REQ-015 A bit event is a synchronized ser_clk 0->1 transition that occurs while synchronized ser_frame=1.
REQ-016 The FSM shall have three states: IDLE, SHIFT and COMMIT.
REQ-017 IDLE -> SHIFT on synchronized ser_frame 0->1; clears the shift register and the 5-bit bit counter.
REQ-018 A bit event in the same cycle as the frame rise shall be captured as bit 0.
REQ-019 In SHIFT, each bit event shall shift ser_data into the LSB of the 16-bit shift register and increment the counter.
REQ-020 The counter shall saturate at 16; further bit events shall not alter the shift register and shall set a sticky overrun flag for the frame.
REQ-021 SHIFT -> COMMIT on synchronized ser_frame 1->0 when count==16 and no overrun.
REQ-022 SHIFT -> IDLE on synchronized ser_frame 1->0 when count!=16 or overrun; frame_err pulses for 1 cycle and opcode/instr keep their previous values.
REQ-023 COMMIT shall load opcode=shreg[15:12] and instr=shreg[11:0], pulse inst_done high for exactly that one cycle, then go to IDLE.
REQ-024 opcode and instr shall be registered and change only in COMMIT.
REQ-025 A bit event with the frame low shall be ignored.
REQ-026 A ser_frame rise while in COMMIT shall be honoured on the next IDLE cycle; no frame shall be lost.
REQ-027 btn_edge shall pulse one cycle after the synchronized btn_in 0->1 transition and be independent of the FSM state; btn_edge and inst_done may assert in the same cycle.
REQ-028 Latency from the raw ser_frame fall to inst_done shall be SYNC_STAGES+2 clk cycles.

Reset
REQ-029 While rst_n=0: state=IDLE; opcode=0, instr=0, inst_done=0, btn_edge=0, frame_err=0; counter, shift register, overrun flag and all synchronizer flops cleared.
REQ-030 Reset asserted mid-frame shall discard the partial frame with no inst_done and no frame_err; after release a new frame is required.
REQ-031 Synchronizer flops shall reset to 0, so a pin held high through reset release produces an edge or frame start only after it first goes low.

Structure
REQ-032 Shared package holds FRAME_BITS=16, OPCODE_W=4, INSTR_W=12 and the state encoding (IDLE=0, SHIFT=1, COMMIT=2).
REQ-033 One sub-module, sync_edge (SYNC_STAGES synchronizer plus rising-edge pulse), shall be instantiated for ser_clk and btn_in; plain synchronizers serve ser_data and ser_frame.
REQ-034 Outputs connect directly to cpu_core opcode, instr, inst_done and btn_edge.

Verification
REQ-035 Frame 0x8A53 (16 edges) -> one inst_done pulse; opcode=0x8, instr=0xA53; frame_err=0.
REQ-036 Frame of 15 edges with data 0x1234 -> frame_err pulse; no inst_done; outputs keep their previous values.
REQ-037 Frame of 17 edges -> frame_err pulse; outputs unchanged.
REQ-038 Reset after 8 edges, then a full 0x0FFF frame -> single inst_done; opcode=0x0, instr=0xFFF.
REQ-039 btn_in pulse during an active frame -> exactly one btn_edge pulse; frame completes normally.
REQ-040 Two frames 0x1001 then 0xF00E with a 1-cycle frame gap -> two inst_done pulses, outputs matching each frame in order.
